// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Purpose  : Shared types, default timing constants and the channel scaling
//            helper used by the WS2812 frame sequencer.
// Contents : seq_state_t - frame sequencer state encoding
//            grb_t       - one pixel word, GRB order
//            scale8()    - (channel * (brightness + 1)) >> 8
// Revision : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_SEND       = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_LATCH      = 3'd4,
        ST_WAIT_FRAME = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // 20 ms frame period and 60 us latch gap at a 50 MHz clock
    localparam int C_DEF_NUM_LEDS         = 8;
    localparam int C_DEF_CYCLES_PER_FRAME = 1_000_000;
    localparam int C_DEF_LATCH_CYCLES     = 3000;

    // brightness+1 makes 255 an exact pass-through and 0 give 0
    function automatic logic [7:0] scale8(input logic [7:0] channel,
                                          input logic [7:0] brightness);
        logic [15:0] prod;
        prod = 16'(channel) * (16'(brightness) + 16'd1);
        return prod[15:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_timer
// Purpose  : Frame period counter. Counts 0..CYCLES_PER_FRAME-1 while run is
//            high and is held at 0 while run is low. The wrap event is the
//            cycle in which the count equals 0.
// Ports    : clk   - system clock
//            reset - synchronous, active-high reset
//            run   - count enable; low forces the count back to 0
//            wrap  - high whenever the count is 0
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_frame_timer
    import ws2812_pkg::*;
#(
    parameter int CYCLES_PER_FRAME = C_DEF_CYCLES_PER_FRAME
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic wrap
);

    localparam int C_CNT_W = (CYCLES_PER_FRAME > 1) ? $clog2(CYCLES_PER_FRAME) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(CYCLES_PER_FRAME - 1);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_count <= '0;
        end else if (r_count == C_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + C_CNT_W'(1);
        end
    end

    assign wrap = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_sequencer
// Purpose  : Frame-level WS2812 controller. Once per frame period it fetches
//            NUM_LEDS colour words from the upstream source, hands each to
//            the bit-level driver, waits for the driver to drain, enforces
//            the latch gap and counts completed frames.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            enable                - run frames while high
//            brightness            - (WS2812_BRIGHTNESS_EN only) global level
//            frame_tick            - one-cycle pulse at each frame start
//            pix_req/pix_idx       - pixel request and index to the source
//            pix_valid/pix_color   - source response, GRB colour
//            drv_valid/drv_data    - word offered to the driver
//            drv_ready/drv_idle    - driver accept / driver line idle
//            busy                  - frame in progress
//            overrun               - sticky, period expired mid-frame
//            frame_count           - completed frames (wraps)
// Config   : WS2812_BRIGHTNESS_EN  - adds the brightness port and scales each
//            captured channel by (brightness+1)/256.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS         = C_DEF_NUM_LEDS,
    parameter int CYCLES_PER_FRAME = C_DEF_CYCLES_PER_FRAME,
    parameter int LATCH_CYCLES     = C_DEF_LATCH_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]  brightness,
`endif
    output logic        frame_tick,
    output logic        pix_req,
    output logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] pix_idx,
    input  logic        pix_valid,
    input  logic [23:0] pix_color,
    output logic        drv_valid,
    output logic [23:0] drv_data,
    input  logic        drv_ready,
    input  logic        drv_idle,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam int C_IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int C_LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX   = C_IDX_W'(NUM_LEDS - 1);
    localparam logic [C_LAT_W-1:0] C_LATCH_LAST = C_LAT_W'(LATCH_CYCLES - 1);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [C_IDX_W-1:0] r_pix_idx;
    grb_t               r_drv_word;
    grb_t               w_scaled;
    logic [C_LAT_W-1:0] r_latch_cnt;
    logic               r_overrun;
    logic [15:0]        r_frame_count;

    logic w_wrap;
    logic w_run;
    logic w_tick;
    logic w_capture;
    logic w_advance;
    logic w_latch_done;
    logic w_overrun_set;

    // The period keeps running through a frame even after enable drops so the
    // frame can finish and the return to IDLE lands on a wrap.
    assign w_run = enable || (r_state != ST_IDLE);

    ws2812_frame_timer #(
        .CYCLES_PER_FRAME (CYCLES_PER_FRAME)
    ) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .wrap  (w_wrap)
    );

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] r_brightness;
    grb_t       w_pix;

    assign w_pix    = pix_color;
    assign w_scaled = '{g: scale8(w_pix.g, r_brightness),
                        r: scale8(w_pix.r, r_brightness),
                        b: scale8(w_pix.b, r_brightness)};

    // Latched at the frame tick so one frame never mixes two levels
    always_ff @(posedge clk) begin
        if (reset) begin
            r_brightness <= '0;
        end else if (w_tick) begin
            r_brightness <= brightness;
        end
    end
`else
    assign w_scaled = pix_color;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_tick        = 1'b0;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_latch_done  = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wrap && enable) begin
                    w_tick       = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_overrun_set = w_wrap;
                if (pix_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                w_overrun_set = w_wrap;
                if (drv_ready) begin
                    if (r_pix_idx < C_LAST_IDX) begin
                        w_advance    = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_overrun_set = w_wrap;
                if (drv_idle) begin
                    w_next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_overrun_set = w_wrap;
                if (r_latch_cnt == C_LATCH_LAST) begin
                    w_latch_done = 1'b1;
                    w_next_state = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (w_wrap) begin
                    if (enable) begin
                        w_tick       = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_idx     <= '0;
            r_drv_word    <= '0;
            r_latch_cnt   <= '0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_tick) begin
                r_pix_idx <= '0;
            end else if (w_advance) begin
                r_pix_idx <= r_pix_idx + C_IDX_W'(1);
            end
            if (w_capture) begin
                r_drv_word <= w_scaled;
            end
            if (r_state == ST_LATCH && !w_latch_done) begin
                r_latch_cnt <= r_latch_cnt + C_LAT_W'(1);
            end else begin
                r_latch_cnt <= '0;
            end
            if (w_latch_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // The tick is decoded combinationally from IDLE/WAIT_FRAME, both of which
    // are the reset state's neighbours, so it is masked while reset is high.
    assign frame_tick  = w_tick && !reset;
    assign pix_req     = (r_state == ST_FETCH);
    assign drv_valid   = (r_state == ST_SEND);
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_WAIT_FRAME);
    assign pix_idx     = r_pix_idx;
    assign drv_data    = r_drv_word;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_frame_sequencer
// Purpose  : Self-checking bench for ws2812_frame_sequencer with NUM_LEDS=4,
//            CYCLES_PER_FRAME=2000, LATCH_CYCLES=100 and a 20 ns clock.
//            Expected words, tick spacing, latch length and frame counts come
//            from a small reference model kept here.
// Config   : WS2812_BRIGHTNESS_EN - connects and models the brightness port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ws2812_frame_sequencer;

    localparam int NL  = 4;
    localparam int CPF = 2000;
    localparam int LAT = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_tick;
    logic        pix_req;
    logic [1:0]  pix_idx;
    logic        pix_valid;
    logic [23:0] pix_color;
    logic        drv_valid;
    logic [23:0] drv_data;
    logic        drv_ready;
    logic        drv_idle;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_count;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]  brightness;
`endif

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   n_ticks = 0;
    int   exp_fc = 0;
    logic [7:0] bri = 8'd255;

    ws2812_frame_sequencer #(
        .NUM_LEDS         (NL),
        .CYCLES_PER_FRAME (CPF),
        .LATCH_CYCLES     (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .frame_tick  (frame_tick),
        .pix_req     (pix_req),
        .pix_idx     (pix_idx),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color),
        .drv_valid   (drv_valid),
        .drv_data    (drv_data),
        .drv_ready   (drv_ready),
        .drv_idle    (drv_idle),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_tick === 1'b1) n_ticks <= n_ticks + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each channel scaled by (brightness+1)/256 when enabled
    function automatic logic [23:0] exp_word(input logic [23:0] c);
`ifdef WS2812_BRIGHTNESS_EN
        int g, r, b;
        g = int'(c[23:16]) * (int'(bri) + 1) / 256;
        r = int'(c[15:8])  * (int'(bri) + 1) / 256;
        b = int'(c[7:0])   * (int'(bri) + 1) / 256;
        return {g[7:0], r[7:0], b[7:0]};
`else
        return c;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"},  32'(frame_tick),  32'd0);
        check({tag, "_req"},   32'(pix_req),     32'd0);
        check({tag, "_idx"},   32'(pix_idx),     32'd0);
        check({tag, "_valid"}, 32'(drv_valid),   32'd0);
        check({tag, "_data"},  32'(drv_data),    32'd0);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_ovr"},   32'(overrun),     32'd0);
        check({tag, "_fc"},    32'(frame_count), 32'd0);
    endtask

    task automatic set_bri(input logic [7:0] b);
        bri = b;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = b;
`endif
    endtask

    // Returns the cycle of the tick and leaves the bench one cycle later
    task automatic wait_tick(output int t);
        int n;
        n = 0;
        #1;
        while (frame_tick !== 1'b1 && n < 3 * CPF) begin
            @(negedge clk); #1;
            n++;
        end
        check("tick_seen", 32'(frame_tick), 32'd1);
        t = cyc;
        @(negedge clk);
    endtask

    task automatic do_pixel(input int idx, input logic [23:0] col, input int sdel, input int rdel);
        check("req", 32'(pix_req), 32'd1);
        check("idx", 32'(pix_idx), 32'(idx));
        check("fetch_no_valid", 32'(drv_valid), 32'd0);
        for (int i = 0; i < sdel; i++) begin
            pix_valid = 1'b0;
            drv_ready = 1'($urandom);
            @(negedge clk);
            check("req_hold", 32'(pix_req), 32'd1);
            check("idx_hold", 32'(pix_idx), 32'(idx));
            check("fetch_no_valid", 32'(drv_valid), 32'd0);
        end
        pix_valid = 1'b1;
        pix_color = col;
        drv_ready = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_color = 24'($urandom);
        check("valid_after_cap", 32'(drv_valid), 32'd1);
        check("req_drop", 32'(pix_req), 32'd0);
        check("word", 32'(drv_data), 32'(exp_word(col)));
        for (int i = 0; i < rdel; i++) begin
            drv_ready = 1'b0;
            pix_valid = 1'($urandom);
            @(negedge clk);
            check("stall_word", 32'(drv_data), 32'(exp_word(col)));
            check("stall_no_req", 32'(pix_req), 32'd0);
            check("stall_valid", 32'(drv_valid), 32'd1);
        end
        pix_valid = 1'b0;
        drv_ready = 1'b1;
        @(negedge clk);
        drv_ready = 1'b0;
        if (idx < NL - 1) begin
            check("next_req", 32'(pix_req), 32'd1);
            check("next_idx", 32'(pix_idx), 32'(idx + 1));
        end else begin
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_no_req", 32'(pix_req), 32'd0);
            check("drain_no_valid", 32'(drv_valid), 32'd0);
        end
    endtask

    // mode 0: random colours/latencies, 1: {idx,idx,idx} with 1-cycle source,
    // 2: every pixel FF8000
    task automatic pixels(input int mode, input int first, input int last,
                          input int stall_px, input int stall_len);
        logic [23:0] c;
        logic [7:0]  p8;
        int sdel, rdel;
        for (int p = first; p <= last; p++) begin
            p8   = p[7:0];
            c    = (mode == 1) ? {p8, p8, p8} : (mode == 2) ? 24'hFF8000 : 24'($urandom);
            sdel = (mode == 0) ? int'($urandom_range(0, 3)) : 1;
            rdel = (p == stall_px) ? stall_len : ((mode == 0) ? int'($urandom_range(0, 2)) : 0);
            do_pixel(p, c, sdel, rdel);
        end
    endtask

    task automatic drain_latch(input int idel);
        int n;
        for (int i = 0; i < idel; i++) begin
            drv_idle = 1'b0;
            @(negedge clk);
            check("drain_wait_busy", 32'(busy), 32'd1);
            check("drain_wait_fc", 32'(frame_count), 32'(exp_fc));
        end
        drv_idle = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < LAT + 20) begin
            n++;
            @(negedge clk);
        end
        exp_fc++;
        check("latch_len", 32'(n), 32'(LAT));
        check("frame_count", 32'(frame_count), 32'(exp_fc));
    endtask

    task automatic run_frame(input int mode, input int stall_px, input int stall_len,
                             input int idel, output int t);
        set_bri((mode == 2) ? 8'd128 : 8'($urandom));
        wait_tick(t);
        pixels(mode, 0, NL - 1, stall_px, stall_len);
        drain_latch(idel);
    endtask

    initial begin
        int t0, t1, t2, t3, t4, t5, t6, t7, t8, rel, nt;
        reset     = 1'b1;
        enable    = 1'b0;
        pix_valid = 1'b0;
        pix_color = 24'h0;
        drv_ready = 1'b0;
        drv_idle  = 1'b1;
        set_bri(8'd255);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_disabled_busy", 32'(busy), 32'd0);
        check("idle_disabled_ticks", 32'(n_ticks), 32'd0);

        // Basic frame, index pattern, then the period from tick to tick
        enable = 1'b1;
        run_frame(1, -1, 0, 0, t0);
        check("ovr_clean", 32'(overrun), 32'd0);

        // Driver stall on pixel 1
        run_frame(0, 1, 50, 0, t1);
        check("period1", 32'(t1 - t0), 32'(CPF));

        // Driver drains 30 cycles after the last transfer
        run_frame(0, -1, 0, 30, t2);
        check("period2", 32'(t2 - t1), 32'(CPF));
        check("ovr_clean2", 32'(overrun), 32'd0);

        // Stall across the period boundary: overrun, next tick one period late
        nt = n_ticks;
        run_frame(0, 2, 2500, 0, t3);
        check("period3", 32'(t3 - t2), 32'(CPF));
        check("overrun_set", 32'(overrun), 32'd1);
        check("tick_suppressed", 32'(n_ticks), 32'(nt + 1));
        run_frame(2, -1, 0, 0, t4);
        check("period_after_ovr", 32'(t4 - t3), 32'(2 * CPF));
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while pixel 2 is requested
        set_bri(8'($urandom));
        wait_tick(t5);
        check("period4", 32'(t5 - t4), 32'(CPF));
        pixels(0, 0, 1, -1, 0);
        check("mid_idx", 32'(pix_idx), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset  = 1'b0;
        exp_fc = 0;
        rel    = cyc;
        run_frame(0, -1, 0, 0, t6);
        check("tick_on_release", 32'(t6 - rel), 32'd0);
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Enable dropped mid-frame: frame finishes, then IDLE at the next wrap
        set_bri(8'($urandom));
        wait_tick(t7);
        check("period5", 32'(t7 - t6), 32'(CPF));
        pixels(0, 0, 0, -1, 0);
        enable = 1'b0;
        pixels(0, 1, NL - 1, -1, 0);
        drain_latch(0);
        nt = n_ticks;
        while (cyc < t7 + CPF + 10) @(negedge clk);
        check("disabled_no_tick", 32'(n_ticks), 32'(nt));
        check("disabled_busy", 32'(busy), 32'd0);
        check("disabled_req", 32'(pix_req), 32'd0);
        check("disabled_fc", 32'(frame_count), 32'(exp_fc));

        // From IDLE a re-enable starts a frame at once with index 0
        enable = 1'b1;
        rel    = cyc;
        wait_tick(t8);
        check("reenable_tick", 32'(t8 - rel), 32'd0);
        check("reenable_idx", 32'(pix_idx), 32'd0);
        check("reenable_req", 32'(pix_req), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_frame_sequencer.md
# ws2812_frame_sequencer

Frame-level controller for a WS2812 LED strip: it sequences one frame of pixel data from an upstream colour source to the bit-level WS2812 driver. Each frame it requests NUM_LEDS colour words, streams them to the driver over a valid/ready handshake, waits for the driver to drain, then enforces the latch (reset) low gap. It paces frames at a fixed period and emits the frame tick that advances the fade controller by one step. It sits between the fading controller and the WS2812 driver inside the fade top level.

## Interface
Parameters:
- NUM_LEDS, 8, number of pixels per frame (≥1)
- CYCLES_PER_FRAME, 1_000_000, frame period in clk cycles (20 ms at 50 MHz)
- LATCH_CYCLES, 3000, latch gap in clk cycles (60 µs at 50 MHz)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run frames while high
- frame_tick  out  1  one-cycle pulse at each frame start; upstream advances its fade step
- pix_req  out  1  pixel request; held until pix_valid
- pix_idx  out  $clog2(NUM_LEDS) (min 1)  index of requested pixel; stable while pix_req is high
- pix_valid  in  1  pix_color valid; a pixel is captured in any cycle where pix_req && pix_valid
- pix_color  in  24  pixel colour, GRB order: G[23:16], R[15:8], B[7:0]
- drv_valid  out  1  word offered to the driver
- drv_data  out  24  GRB word; stable while drv_valid is high
- drv_ready  in  1  driver accepts; a word transfers when drv_valid && drv_ready
- drv_idle  in  1  driver has finished shifting and its line is low
- busy  out  1  high in every state except IDLE and WAIT_FRAME
- overrun  out  1  sticky; set when a frame period expires before the frame completes
- frame_count  out  16  completed frames, wraps at 0xFFFF→0

## Operation
- States: IDLE, FETCH, SEND, DRAIN, LATCH, WAIT_FRAME.
- Period counter:
  - runs 0..CYCLES_PER_FRAME-1 while enable=1 or state≠IDLE.
  - held at 0 in IDLE with enable=0.
  - the wrap event is count==0.
- IDLE→FETCH: on wrap with enable=1. frame_tick=1 in that cycle; pix_idx=0.
- FETCH:
  - pix_req=1.
  - on pix_valid, capture the colour into drv_data and go to SEND.
- SEND:
  - drv_valid=1.
  - on transfer, if pix_idx<NUM_LEDS-1: pix_idx+1 and go to FETCH; else go to DRAIN.
- DRAIN: wait for drv_idle=1, then go to LATCH.
- LATCH:
  - count exactly LATCH_CYCLES cycles.
  - on exit, frame_count+1 and go to WAIT_FRAME.
- WAIT_FRAME:
  - on wrap: if enable=1, pulse frame_tick and go to FETCH; else go to IDLE.
- Overrun:
  - if a wrap occurs in FETCH/SEND/DRAIN/LATCH, set overrun=1 and suppress frame_tick.
  - the next frame starts at the following wrap.
  - only reset clears overrun.
- enable deasserted mid-frame: the current frame completes through LATCH, then WAIT_FRAME→IDLE at the next wrap.
- Reset (any state): next cycle state=IDLE, period/latch counters=0, pix_idx=0, drv_data=0, all outputs 0.

## Timing
- frame_tick at cycle T → pix_req=1 at T+1.
- pix_valid at cycle P → drv_valid=1 at P+1, pix_req=0 at P+1.
- Transfer at cycle D → next pix_req at D+1, or DRAIN at D+1 after the last pixel.
- drv_idle first seen at cycle I → LATCH occupies cycles I+1..I+LATCH_CYCLES.
- pix_valid without pix_req: ignored. drv_ready without drv_valid: ignored.
- Minimum frame length: NUM_LEDS×(2 + driver accept latency) + drain time + LATCH_CYCLES + 1 cycles. With CYCLES_PER_FRAME below this, every other period overruns.

## Configuration
- WS2812_BRIGHTNESS_EN defined:
  - adds port brightness (in, 8), sampled into a register on each frame_tick and constant for the frame.
  - each captured channel becomes (c×(brightness+1))>>8; 255 passes through, 0 gives 0.
  - scaling is applied at capture and adds no latency.
- Not defined: the brightness port is absent and pix_color passes to drv_data unchanged.

## Structure
- ws2812_pkg holds:
  - state enum seq_state_t
  - grb_t typedef (packed struct g, r, b; 8 bits each)
  - default timing constants
  - function scale8(channel, brightness)
- Sub-module ws2812_frame_timer: period counter and wrap pulse, with enable/hold-at-0.
- The FSM, pixel index, latch counter and stats stay in the top module.

## Test plan
Setup: NUM_LEDS=4, CYCLES_PER_FRAME=2000, LATCH_CYCLES=100, 20 ns clock.
1. Reset, enable=1, source answers in 1 cycle with {idx,idx,idx}, drv_ready=1, drv_idle=1 → words 000000, 010101, 020202, 030303 in order; frame_tick every 2000 cycles; frame_count=1 after the first latch; overrun=0.
2. drv_ready=0 for 50 cycles on pixel 1 → drv_data holds 010101 for all 50 cycles; no pix_req during the stall; pixel 2 is requested the cycle after the transfer.
3. drv_idle goes high 30 cycles after the last transfer → LATCH lasts exactly 100 cycles after drv_idle; frame_count increments once.
4. drv_ready=0 for 2500 cycles → overrun=1; no frame_tick at cycle 2000; next frame_tick at cycle 4000.
5. Reset asserted while pix_idx=2 → every output is 0 the next cycle. After release: frame_tick, then pix_idx=0.
6. WS2812_BRIGHTNESS_EN, brightness=128, pix_color=FF8000 → drv_data=804000. Macro undefined → drv_data=FF8000.
